// File: rtl/fft_job_sched.sv
// Round-robin scheduler that shares one FFT core among N_REQ requesters:
// grant, capture frame, pulse core reset, start, wait for done (bounded), return tagged result.
module fft_job_sched #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int VEC_W   = 1024,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_val_i,
   output logic [N_REQ-1:0]       req_rdy_o,
   input  logic [N_REQ*VEC_W-1:0] req_re_i,
   input  logic [N_REQ*VEC_W-1:0] req_im_i,
   output logic                   core_rst_n_o,
   output logic                   core_val_o,
   output logic [VEC_W-1:0]       core_re_o,
   output logic [VEC_W-1:0]       core_im_o,
   input  logic                   core_done_i,
   input  logic [VEC_W-1:0]       core_re_i,
   input  logic [VEC_W-1:0]       core_im_i,
   output logic                   res_val_o,
   input  logic                   res_rdy_i,
   output logic [ID_W-1:0]        res_id_o,
   output logic [VEC_W-1:0]       res_re_o,
   output logic [VEC_W-1:0]       res_im_o,
   output logic                   busy_o,
   output logic                   timeout_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_START,
      S_RUN,
      S_OUT
   } state_t;

   state_t           state, state_next;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  job_id;
   logic [ID_W-1:0]  grant;
   logic             grant_found;
   logic [CNT_W-1:0] wait_cnt;

   // Descending scan so the lowest offset from rr_ptr is written last and wins.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_val_i[(int'(rr_ptr) + i) % N_REQ]) begin
            grant       = ID_W'((int'(rr_ptr) + i) % N_REQ);
            grant_found = 1'b1;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_next = state;
      req_rdy_o  = '0;
      core_val_o = 1'b0;
      res_val_o  = 1'b0;
      busy_o     = 1'b1;
      timeout_o  = 1'b0;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (grant_found) begin
               req_rdy_o[grant] = 1'b1;
               state_next       = S_CLR;
            end
         end
         S_CLR:   state_next = S_START;
         S_START: begin
            core_val_o = 1'b1;
            state_next = S_RUN;
         end
         S_RUN: begin
            if (core_done_i) begin
               state_next = S_OUT;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               timeout_o  = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_OUT: begin
            res_val_o = 1'b1;
            if (res_rdy_i) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         core_rst_n_o <= 1'b0;
      end else begin
         state        <= state_next;
         // Registered so the core sees a clean reset exactly during the CLR cycle.
         core_rst_n_o <= (state_next != S_CLR);
      end
   end

   // NOTE: the wide frame/result registers are reset too, so nothing stale is visible after rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         job_id    <= '0;
         wait_cnt  <= '0;
         core_re_o <= '0;
         core_im_o <= '0;
         res_id_o  <= '0;
         res_re_o  <= '0;
         res_im_o  <= '0;
      end else begin
         if (state == S_IDLE && grant_found) begin
            core_re_o <= req_re_i[int'(grant)*VEC_W +: VEC_W];
            core_im_o <= req_im_i[int'(grant)*VEC_W +: VEC_W];
            job_id    <= grant;
            rr_ptr    <= ID_W'((int'(grant) + 1) % N_REQ);
         end
         if (state == S_START) begin
            wait_cnt <= '0;
         end else if (state == S_RUN) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if (state == S_RUN && core_done_i) begin
            res_re_o <= core_re_i;
            res_im_o <= core_im_i;
            res_id_o <= job_id;
         end
      end
   end

endmodule

// File: tb/tb_fft_job_sched.sv
// Directed bench for fft_job_sched: behavioural sticky-done core, grant logging, hand-computed expectations.
module tb_fft_job_sched;

   localparam int N  = 4;
   localparam int VW = 1024;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_val_i;
   logic [N-1:0]    req_rdy_o;
   logic [N*VW-1:0] req_re_i, req_im_i;
   logic            core_rst_n_o, core_val_o;
   logic [VW-1:0]   core_re_o, core_im_o;
   logic            core_done_i = 1'b0;
   logic [VW-1:0]   core_re_i = '1, core_im_i = '1;
   logic            res_val_o, res_rdy_i;
   logic [1:0]      res_id_o;
   logic [VW-1:0]   res_re_o, res_im_o;
   logic            busy_o, timeout_o;

   fft_job_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req_val_i(req_val_i), .req_rdy_o(req_rdy_o),
      .req_re_i(req_re_i), .req_im_i(req_im_i),
      .core_rst_n_o(core_rst_n_o), .core_val_o(core_val_o),
      .core_re_o(core_re_o), .core_im_o(core_im_o),
      .core_done_i(core_done_i), .core_re_i(core_re_i), .core_im_i(core_im_i),
      .res_val_o(res_val_o), .res_rdy_i(res_rdy_i), .res_id_o(res_id_o),
      .res_re_o(res_re_o), .res_im_o(res_im_o),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int core_lat = 3;
   int core_cnt = -1;
   int val_pulses = 0;
   int to_pulses = 0;
   int viol = 0;
   bit res_seen = 1'b0;
   int grants[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] fr_re(input int k);
      return {32{32'hC0DE_0000 + 32'(k)}};
   endfunction

   function automatic logic [VW-1:0] fr_im(input int k);
      return {32{32'h1234_5600 ^ 32'(k * 17)}};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res(input int max, output int n);
      n = 0;
      while (res_val_o !== 1'b1 && n < max) begin
         cyc();
         n++;
      end
      if (res_val_o !== 1'b1) check("res_wait", 64'(res_val_o), 64'd1);
   endtask

   task automatic wait_grants(input int cnt, input int max);
      int k = 0;
      while (grants.size() < cnt && k < max) begin
         cyc();
         k++;
      end
      if (grants.size() < cnt) check("grant_wait", 64'(grants.size()), 64'(cnt));
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (busy_o !== 1'b0 && k < max) begin
         cyc();
         k++;
      end
      if (busy_o !== 1'b0) check("idle_wait", 64'(busy_o), 64'd0);
   endtask

   // Core model: done is a sticky level, cleared only by the core reset.
   always begin
      @(posedge clk);
      #1;
      if (core_rst_n_o !== 1'b1) begin
         core_done_i = 1'b0;
         core_cnt    = -1;
         core_re_i   = '1;
         core_im_i   = '1;
      end else if (core_val_o === 1'b1) begin
         core_cnt = 0;
      end else if (core_cnt >= 0) begin
         core_cnt++;
         if (core_lat > 0 && core_cnt == core_lat) begin
            core_done_i = 1'b1;
            core_re_i   = ~core_re_o;
            core_im_i   = core_re_o ^ core_im_o;
         end
      end
   end

   // Mid-cycle monitor: grant log, pulse counters and ready legality.
   always @(negedge clk) begin
      if (core_val_o === 1'b1) val_pulses++;
      if (timeout_o === 1'b1) to_pulses++;
      if (res_val_o === 1'b1) res_seen = 1'b1;
      if (req_rdy_o != '0 && (busy_o || !$onehot(req_rdy_o) || (req_rdy_o & ~req_val_i) != '0)) viol++;
      if (!busy_o && (req_rdy_o & req_val_i) != '0)
         for (int i = 0; i < N; i++) if (req_rdy_o[i]) grants.push_back(i);
   end

   initial begin
      int n;
      int base;
      bit stable;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      rst_n = 1'b0;
      req_val_i = '0;
      res_rdy_i = 1'b0;
      for (int k = 0; k < N; k++) begin
         req_re_i[k*VW +: VW] = fr_re(k);
         req_im_i[k*VW +: VW] = fr_im(k);
      end
      repeat (2) cyc();
      check("rst_rdy", 64'(req_rdy_o), 64'd0);
      check("rst_core_rst_n", 64'(core_rst_n_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_outs", 64'({core_val_o, res_val_o, timeout_o, res_id_o}), 64'd0);
      rst_n = 1'b1;
      cyc();
      check("core_rst_release", 64'(core_rst_n_o), 64'd1);

      // All four held continuously: strict rotation starting at 0.
      res_rdy_i = 1'b1;
      core_lat  = 3;
      req_val_i = 4'b1111;
      wait_grants(5, 200);
      req_val_i = 4'b0001;
      res_rdy_i = 1'b0;
      for (int i = 0; i < 5; i++)
         check($sformatf("rr_order_%0d", i), 64'(grants.size() > i ? grants[i] : -1), 64'(exp_order[i]));

      // ch0 pending, ch3 arrives in OUT with rr_ptr=1: ch3 wins.
      wait_res(50, n);
      req_val_i = 4'b1001;
      res_rdy_i = 1'b1;
      #1;
      check("rdy_in_out", 64'(req_rdy_o), 64'd0);
      cyc();
      check("rr_skip_grant", 64'(req_rdy_o), 64'b1000);
      wait_grants(7, 100);
      req_val_i = '0;
      check("grant_ch0_after_ch3", 64'(grants.size() > 6 ? grants[6] : -1), 64'd0);
      wait_idle(100);

      // Single ch2 job, done 18 cycles after start.
      res_rdy_i = 1'b0;
      core_lat  = 18;
      cyc();
      req_val_i = 4'b0100;
      #1;
      check("ch2_rdy", 64'(req_rdy_o), 64'b0100);
      val_pulses = 0;
      cyc();
      req_val_i = '0;
      #1;
      check("clr_state", 64'({busy_o, core_rst_n_o, req_rdy_o}), 64'b1_0_0000);
      cyc();
      check("start_pulse", 64'({core_val_o, core_rst_n_o}), 64'b11);
      check("core_frame", 64'(core_re_o == fr_re(2) && core_im_o == fr_im(2)), 64'd1);
      wait_res(100, n);
      check("latency_start_to_res", 64'(n), 64'd19);
      check("core_val_pulses", 64'(val_pulses), 64'd1);
      check("res_id_ch2", 64'(res_id_o), 64'd2);
      check("res_data_ch2", 64'(res_re_o == ~fr_re(2) && res_im_o == (fr_re(2) ^ fr_im(2))), 64'd1);

      // Backpressure: 10 cycles held in OUT while ch1 waits.
      req_val_i = 4'b0010;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check($sformatf("hold_%0d", i), 64'({res_val_o, req_rdy_o}), 64'b1_0000);
         if (res_re_o !== ~fr_re(2) || res_im_o !== (fr_re(2) ^ fr_im(2)) || res_id_o !== 2'd2)
            stable = 1'b0;
      end
      check("hold_stable", 64'(stable), 64'd1);
      res_rdy_i = 1'b1;
      core_lat  = 0;
      cyc();
      res_rdy_i = 1'b0;
      #1;
      check("accept_to_idle", 64'({res_val_o, busy_o, req_rdy_o}), 64'b0_0_0010);

      // ch1 job never completes: timeout 64 cycles after START.
      cyc();
      req_val_i = '0;
      cyc();
      check("t_start", 64'(core_val_o), 64'd1);
      to_pulses = 0;
      res_seen  = 1'b0;
      n = 0;
      while (timeout_o !== 1'b1 && n < 100) begin
         cyc();
         n++;
      end
      check("timeout_delay", 64'(n), 64'd64);
      cyc();
      check("timeout_idle", 64'(busy_o), 64'd0);
      check("timeout_pulses", 64'(to_pulses), 64'd1);
      check("timeout_no_res", 64'(res_seen), 64'd0);

      // Next job starts (rr_ptr=2, only ch0 asks), then reset hits mid-RUN.
      core_lat  = 30;
      req_val_i = 4'b0001;
      #1;
      check("post_timeout_grant", 64'(req_rdy_o), 64'b0001);
      cyc();
      req_val_i = '0;
      cyc();
      check("post_timeout_start", 64'(core_val_o), 64'd1);
      cyc();
      cyc();
      rst_n = 1'b0;
      #1;
      check("arst_ctrl", 64'({req_rdy_o, core_rst_n_o, core_val_o, res_val_o, busy_o, timeout_o}), 64'd0);
      check("arst_data", 64'(core_re_o == '0 && res_re_o == '0 && res_id_o == '0), 64'd1);
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      check("arst_release", 64'(core_rst_n_o), 64'd1);
      core_lat  = 5;
      res_rdy_i = 1'b1;
      req_val_i = 4'b1111;
      #1;
      check("arst_rr_zero", 64'(req_rdy_o), 64'b0001);
      base = grants.size();
      wait_grants(base + 1, 20);
      req_val_i = '0;
      wait_res(50, n);
      check("arst_job_res", 64'({res_id_o, res_re_o == ~fr_re(0), res_im_o == (fr_re(0) ^ fr_im(0))}), 64'b00_1_1);
      wait_idle(20);
      check("rdy_legal", 64'(viol), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
